// File: rtl/mul_unit_pkg.sv
// Shared types for the RV32M multiply unit: op encoding, CDB packet, defaults.
package mul_unit_pkg;

    localparam int MUL_STAGES = 3;
    localparam int CDB_ROB_W  = 5;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_t;

    typedef struct packed {
        logic [CDB_ROB_W-1:0] rob_entry;
        logic [31:0]          rd_data;
        logic [31:0]          rs1_data;
        logic [31:0]          rs2_data;
        logic [3:0]           mem_rmask;
        logic [3:0]           mem_wmask;
    } cdb_t;

endpackage

// File: rtl/mul_unit_if.sv
// Issue and CDB-side handshake bundle of the multiply unit.
interface mul_unit_if;
    import mul_unit_pkg::*;

    logic                 issue_valid;
    logic                 issue_ready;
    mul_op_t              issue_op;
    logic [31:0]          issue_rs1;
    logic [31:0]          issue_rs2;
    logic [CDB_ROB_W-1:0] issue_rob;
    cdb_t                 mul_result;
    logic                 mul_ready;
    logic                 mul_ack;

    // master = reservation station / CDB arbiter side
    modport master (
        output issue_valid, issue_op, issue_rs1, issue_rs2, issue_rob, mul_ack,
        input  issue_ready, mul_result, mul_ready
    );

    // slave = the multiply unit
    modport slave (
        input  issue_valid, issue_op, issue_rs1, issue_rs2, issue_rob, mul_ack,
        output issue_ready, mul_result, mul_ready
    );

endinterface

// File: rtl/mul_unit_core.sv
// 33x33 signed multiplier with op-dependent operand extension.
module mul_core
    import mul_unit_pkg::*;
(
    input  mul_op_t     op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o
);

    logic        a_sgn;
    logic        b_sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    // Only the low 64 bits of the 66-bit signed product are ever returned, and
    // those equal the truncated product of the operands sign-extended to 64 bits.
    always_comb begin
        a_sgn    = ((op_i == MULH) || (op_i == MULHSU)) && rs1_i[31];
        b_sgn    = (op_i == MULH) && rs2_i[31];
        a_ext    = {{32{a_sgn}}, rs1_i};
        b_ext    = {{32{b_sgn}}, rs2_i};
        prod     = a_ext * b_ext;
        result_o = (op_i == MUL) ? prod[31:0] : prod[63:32];
    end

endmodule

// File: rtl/mul_unit.sv
// Pipelined RV32M multiply unit with elastic, bubble-collapsing backpressure.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int STAGES    = MUL_STAGES,
    parameter int ROB_IDX_W = CDB_ROB_W
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    mul_unit_if.slave   bus
);

    if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
        $error("mul_unit: STAGES must be 1..6");
    end
    if (ROB_IDX_W != CDB_ROB_W) begin : g_bad_rob
        $error("mul_unit: ROB_IDX_W must match cdb_t.rob_entry");
    end

    logic [STAGES-1:0] valid_q, valid_d, adv;
    cdb_t              pkt_q [STAGES];
    cdb_t              pkt_d [STAGES];
    cdb_t              issue_pkt;
    logic [31:0]       core_res;
    logic              tail_full;

    mul_core u_core (
        .op_i     (bus.issue_op),
        .rs1_i    (bus.issue_rs1),
        .rs2_i    (bus.issue_rs2),
        .result_o (core_res)
    );

    // Stage i may advance unless it and every stage after it are occupied and
    // the tail is not being acked; this collapses bubbles behind a stalled tail.
    always_comb begin
        adv = '0;
        for (int i = 0; i < STAGES; i++) begin
            tail_full = 1'b1;
            for (int j = i; j < STAGES; j++) begin
                tail_full = tail_full & valid_q[j];
            end
            adv[i] = !tail_full || bus.mul_ack;
        end
    end

    // Packet entering stage 0: result computed at issue, operands kept for commit.
    always_comb begin
        issue_pkt           = '0;
        issue_pkt.rob_entry = bus.issue_rob;
        issue_pkt.rd_data   = core_res;
        issue_pkt.rs1_data  = bus.issue_rs1;
        issue_pkt.rs2_data  = bus.issue_rs2;
    end

    // Next state: each advancing stage takes its predecessor; flush wins over all loads.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (adv[0]) begin
            valid_d[0] = bus.issue_valid;
            pkt_d[0]   = issue_pkt;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
                valid_d[i] = valid_q[i-1];
                pkt_d[i]   = pkt_q[i-1];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Pipeline registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pkt_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                pkt_q[i] <= pkt_d[i];
            end
        end
    end

    assign bus.issue_ready = adv[0];
    assign bus.mul_ready   = valid_q[STAGES-1];
    assign bus.mul_result  = pkt_q[STAGES-1];

endmodule

// File: tb/tb_mul_unit.sv
// Randomized + directed bench for mul_unit against an in-order queue model.
module tb_mul_unit;
    import mul_unit_pkg::*;

    localparam int S = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    mul_unit_if bus();

    mul_unit #(.STAGES(S), .ROB_IDX_W(CDB_ROB_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Model: in-flight ops oldest first, each with the stage it occupies.
    typedef struct {
        int   pos;
        cdb_t exp;
    } op_t;
    op_t q[$];

    int   errors = 0;
    int   checks = 0;
    bit   known = 0;
    bit   m_iready;
    logic last_ready, last_iready;
    cdb_t last_res;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, p;
        x = (op == 2'd1 || op == 2'd2) ? longint'($signed(a)) : longint'(a);
        y = (op == 2'd1) ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // An op slides forward if the slot ahead is free or its occupant moves;
    // the oldest leaves from the last stage only when acked.
    function automatic void calc_moves(input bit ack, output bit mv[8]);
        for (int k = 0; k < 8; k++) mv[k] = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            if (k == 0) mv[0] = (q[0].pos < S-1) || ack;
            else        mv[k] = (q[k].pos + 1 < q[k-1].pos) || mv[k-1];
        end
    endfunction

    task automatic check();
        bit mv[8];
        bit exp_ready;
        calc_moves(bus.mul_ack, mv);
        m_iready    = (q.size() == 0) || (q[q.size()-1].pos > 0) || mv[q.size()-1];
        last_ready  = bus.mul_ready;
        last_iready = bus.issue_ready;
        last_res    = bus.mul_result;
        if (!known) return;
        exp_ready = (q.size() > 0) && (q[0].pos == S-1);
        chk(bus.mul_ready === exp_ready, "mul_ready", 128'(bus.mul_ready), 128'(exp_ready));
        if (exp_ready)
            chk(bus.mul_result === q[0].exp, "mul_result", 128'(bus.mul_result), 128'(q[0].exp));
        chk(bus.issue_ready === m_iready, "issue_ready", 128'(bus.issue_ready), 128'(m_iready));
    endtask

    task automatic update();
        bit   mv[8];
        op_t  nq[$];
        op_t  t;
        cdb_t e;
        if (!rst) begin
            q.delete();
            known = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            calc_moves(bus.mul_ack, mv);
            for (int k = 0; k < q.size(); k++) begin
                t = q[k];
                if (!(k == 0 && t.pos == S-1 && mv[0])) begin
                    if (mv[k]) t.pos++;
                    nq.push_back(t);
                end
            end
            if (bus.issue_valid && m_iready) begin
                e           = '0;
                e.rob_entry = bus.issue_rob;
                e.rd_data   = ref_mul(bus.issue_op, bus.issue_rs1, bus.issue_rs2);
                e.rs1_data  = bus.issue_rs1;
                e.rs2_data  = bus.issue_rs2;
                t.pos = 0;
                t.exp = e;
                nq.push_back(t);
            end
            q = nq;
        end
    endtask

    task automatic step(input bit iv, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rob, input bit ack, input bit fl, input bit rs);
        bus.issue_valid = iv;
        bus.issue_op    = mul_op_t'(op);
        bus.issue_rs1   = a;
        bus.issue_rs2   = b;
        bus.issue_rob   = rob;
        bus.mul_ack     = ack;
        flush           = fl;
        rst             = rs;
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic idle(input bit ack);
        step(1'b0, 2'd0, $urandom, $urandom, 5'd0, ack, 1'b0, 1'b1);
    endtask

    task automatic single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rob, input logic [31:0] exp, input string name);
        step(1'b1, op, a, b, rob, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= S; k++) begin
            idle(1'b1);
            if (k == S-1) chk(last_ready == 1'b0, {name, "_early"}, 128'(last_ready), 128'(0));
        end
        chk(last_ready == 1'b1, {name, "_ready"}, 128'(last_ready), 128'(1));
        chk(last_res.rd_data == exp, {name, "_data"}, 128'(last_res.rd_data), 128'(exp));
        chk(last_res.rob_entry == rob, {name, "_rob"}, 128'(last_res.rob_entry), 128'(rob));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   acc;
        cdb_t ref_res;
        int   r;

        // reset
        step(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        chk(last_ready == 1'b0, "rst_ready", 128'(last_ready), 128'(0));
        chk(last_res == '0, "rst_result", 128'(last_res), 128'(0));
        chk(last_iready == 1'b1, "rst_iready", 128'(last_iready), 128'(1));

        // basic ops and sign handling
        single(2'd0, 32'h0001_0000, 32'h0001_0000, 5'd1, 32'h0000_0000, "mul_lo");
        single(2'd3, 32'h0001_0000, 32'h0001_0000, 5'd2, 32'h0000_0001, "mulhu_1");
        single(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, "mulh_m1");
        single(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, "mulhu_m1");
        single(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, "mulhsu_m1");
        single(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0001, "mul_m1");

        // backpressure: 4 back-to-back with no ack
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'(i), $urandom, $urandom, 5'(10 + i), 1'b0, 1'b0, 1'b1);
            if (last_iready) acc++;
        end
        chk(acc == 3, "bp_accepted", 128'(acc), 128'(3));
        ref_res = last_res;
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            chk(last_ready && last_res == ref_res, "bp_hold", 128'(last_res), 128'(ref_res));
        end
        idle(1'b1);
        chk(last_iready == 1'b1, "bp_iready_back", 128'(last_iready), 128'(1));
        for (int i = 0; i < 4; i++) idle(1'b1);

        // bubble collapse
        step(1'b1, 2'd0, 32'd3, 32'd5, 5'd20, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 2'd0, 32'd7, 32'd9, 5'd21, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        chk(last_ready && last_res.rob_entry == 5'd21, "bubble_next", 128'(last_res.rob_entry), 128'(21));
        for (int i = 0; i < 3; i++) idle(1'b1);

        // flush with ops in flight and a same-cycle issue
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'(i), $urandom, $urandom, 5'(24 + i), 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'd0, 32'd11, 32'd13, 5'd27, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk(last_ready == 1'b0, "flush_ready", 128'(last_ready), 128'(0));
        for (int i = 0; i < 5; i++) idle(1'b1);
        single(2'd0, 32'd7, 32'd6, 5'd28, 32'd42, "post_flush");

        // reset mid-stream
        step(1'b1, 2'd1, $urandom, $urandom, 5'd29, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd2, $urandom, $urandom, 5'd30, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd3, $urandom, $urandom, 5'd31, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        chk(last_ready == 1'b0, "mid_rst_ready", 128'(last_ready), 128'(0));
        chk(last_res == '0, "mid_rst_result", 128'(last_res), 128'(0));
        chk(last_iready == 1'b1, "mid_rst_iready", 128'(last_iready), 128'(1));
        for (int i = 0; i < 5; i++) idle(1'b1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(199);
            step($urandom_range(99) < 60, 2'($urandom_range(3)), pick(), pick(),
                 5'($urandom_range(31)), $urandom_range(99) < 65, r < 3, r != 199);
        end
        for (int i = 0; i < S + 2; i++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
